// File: rtl/gradual_counter_param_if.sv
// Control/status bus for gradual_counter_param: bounds, mode, enable and load in; count and flags out.
// Wires only, no latency; no backpressure (outputs are valid every cycle).
interface gradual_counter_param_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             turn;
  logic             done;
  logic             cfg_err;

  modport master (
    output en, mode, lo, hi, load, load_val,
    input  count, dir, turn, done, cfg_err
  );

  modport slave (
    input  en, mode, lo, hi, load, load_val,
    output count, dir, turn, done, cfg_err
  );
endinterface

// File: rtl/gradual_counter_param.sv
// Ramp counter stepping by STEP between run-time bounds (bounce/wrap/one-shot); GC_DWELL_EN adds endpoint dwell.
// Latency: one clock from en/load to count/dir/turn/done; cfg_err is combinational.
// Backpressure: none; en=0 holds the count and suppresses any pending turn pulse.
module gradual_counter_param #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int DWELL = 2
) (
  input logic                    clk,
  input logic                    rst,
  gradual_counter_param_if.slave bus
);

  typedef enum logic [1:0] {
    M_BOUNCE  = 2'b00,
    M_WRAP_UP = 2'b01,
    M_WRAP_DN = 2'b10,
    M_ONESHOT = 2'b11
  } mode_e;

  localparam logic [WIDTH:0] STEP_X = (WIDTH + 1)'(STEP);

  // Extra headroom bit keeps count+STEP and lo+STEP from wrapping; overshoot clamps.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] h);
    logic [WIDTH:0] sum;
    sum = {1'b0, c} + STEP_X;
    return (sum > {1'b0, h}) ? h : sum[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] step_dn(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] l);
    logic [WIDTH:0] floor_v;
    floor_v = {1'b0, l} + STEP_X;
    return ({1'b0, c} >= floor_v) ? (c - STEP_X[WIDTH-1:0]) : l;
  endfunction

  logic [WIDTH-1:0] count_q;
  logic             dir_q;
  logic             turn_q;
  logic             done_q;
  mode_e            mode_q;

  mode_e            mode_in;
  logic             cfg_err;
  logic             mode_chg;
  logic             dir_eff;
  logic             done_eff;
  logic             out_rng;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] run_count;
  logic             run_dir;
  logic             run_done;
  logic             run_turn;
  logic             hold_dwell;

  assign mode_in  = mode_e'(bus.mode);
  assign cfg_err  = bus.lo > bus.hi;
  assign mode_chg = mode_in != mode_q;
  assign done_eff = mode_chg ? 1'b0 : done_q;
  assign out_rng  = (count_q < bus.lo) || (count_q > bus.hi);

  always_comb begin
    dir_eff = dir_q;
    if (mode_chg) begin
      case (mode_in)
        M_BOUNCE:  dir_eff = dir_q;
        M_WRAP_DN: dir_eff = 1'b0;
        default:   dir_eff = 1'b1;
      endcase
    end
  end

  always_comb begin
    load_clamped = bus.load_val;
    if (cfg_err || bus.load_val < bus.lo) load_clamped = bus.lo;
    else if (bus.load_val > bus.hi)      load_clamped = bus.hi;
  end

  // Next state for an enabled step, before any endpoint dwell is applied.
  always_comb begin
    run_count = count_q;
    run_dir   = dir_eff;
    run_done  = done_eff;
    run_turn  = 1'b0;
    if (mode_in == M_ONESHOT && done_eff) begin
      run_count = count_q;
    end else if (out_rng) begin
      run_count = (mode_in == M_WRAP_DN) ? bus.hi : bus.lo;
    end else if (bus.lo == bus.hi) begin
      run_count = bus.lo;
      run_done  = done_eff | (mode_in == M_ONESHOT);
    end else begin
      case (mode_in)
        M_BOUNCE: begin
          if (dir_eff && count_q == bus.hi) begin
            run_count = step_dn(bus.hi, bus.lo);
            run_dir   = 1'b0;
            run_turn  = 1'b1;
          end else if (!dir_eff && count_q == bus.lo) begin
            run_count = step_up(bus.lo, bus.hi);
            run_dir   = 1'b1;
            run_turn  = 1'b1;
          end else begin
            run_count = dir_eff ? step_up(count_q, bus.hi) : step_dn(count_q, bus.lo);
          end
        end
        M_WRAP_UP: begin
          run_turn  = count_q == bus.hi;
          run_count = run_turn ? bus.lo : step_up(count_q, bus.hi);
        end
        M_WRAP_DN: begin
          run_turn  = count_q == bus.lo;
          run_count = run_turn ? bus.hi : step_dn(count_q, bus.lo);
        end
        default: begin
          run_count = step_up(count_q, bus.hi);
          run_done  = step_up(count_q, bus.hi) == bus.hi;
        end
      endcase
    end
  end

`ifdef GC_DWELL_EN
  localparam int DW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
  logic [DW-1:0] dwell_q;
  logic [DW-1:0] dwell_base;

  assign dwell_base = mode_chg ? '0 : dwell_q;
  assign hold_dwell = run_turn && (dwell_base < DW'(DWELL));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   dwell_q <= '0;
    else if (bus.load)          dwell_q <= '0;
    else if (!cfg_err && bus.en) dwell_q <= hold_dwell ? dwell_base + 1'b1 : '0;
  end
`else
  assign hold_dwell = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      dir_q   <= 1'b1;
      turn_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= M_BOUNCE;
    end else if (bus.load) begin
      count_q <= load_clamped;
      dir_q   <= mode_in != M_WRAP_DN;
      turn_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= mode_in;
    end else if (!cfg_err && bus.en) begin
      count_q <= hold_dwell ? count_q : run_count;
      dir_q   <= hold_dwell ? dir_eff : run_dir;
      turn_q  <= run_turn & ~hold_dwell;
      done_q  <= run_done;
      mode_q  <= mode_in;
    end else begin
      turn_q  <= 1'b0;
    end
  end

  assign bus.count   = count_q;
  assign bus.dir     = dir_q;
  assign bus.turn    = turn_q;
  assign bus.done    = done_q;
  assign bus.cfg_err = cfg_err;

endmodule
